rc4_keystream_decrypt: RTL and testbench

//  Consumer side of the RC4 keystream store. It reads 4-bit keystream nibbles
//  out of the keystream buffer and packs 8 of them into a 32-bit key word.
//  It XORs that key word with encrypted 32-bit instruction/data words, using

---
 rtl/rc4_keystream_decrypt_if.sv | 32 +++
 rtl/rc4_keystream_decrypt.sv | 116 +++++++++++
 tb/tb_rc4_keystream_decrypt.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_decrypt_if.sv
// Handshake bundle between the keystream buffer, the cipher-word producer and
// the plaintext consumer on one side and rc4_keystream_decrypt on the other.
interface rc4_keystream_decrypt_if #(
   parameter int unsigned KS_DEPTH = 16,
   parameter int unsigned NIB_W    = 4,
   parameter int unsigned WORD_W   = 32
);
   localparam int unsigned ADDR_W = $clog2(KS_DEPTH);

   logic              ks_ready;
   logic              ks_rd_en;
   logic [ADDR_W-1:0] ks_addr;
   logic [NIB_W-1:0]  ks_data;
   logic              ks_rekey;
   logic              ct_valid;
   logic              ct_ready;
   logic [WORD_W-1:0] ct_data;
   logic              pt_valid;
   logic              pt_ready;
   logic [WORD_W-1:0] pt_data;
   logic [7:0]        word_cnt;

   modport master (
      output ks_ready, ks_data, ct_valid, ct_data, pt_ready,
      input  ks_rd_en, ks_addr, ks_rekey, ct_ready, pt_valid, pt_data, word_cnt
   );

   modport slave (
      input  ks_ready, ks_data, ct_valid, ct_data, pt_ready,
      output ks_rd_en, ks_addr, ks_rekey, ct_ready, pt_valid, pt_data, word_cnt
   );
endinterface

// File: rtl/rc4_keystream_decrypt.sv
// Packs keystream nibbles into a key word, XORs it with incoming cipher words
// and hands registered plaintext downstream; requests a re-key once the buffer is spent.
module rc4_keystream_decrypt #(
   parameter int unsigned KS_DEPTH = 16,
   parameter int unsigned NIB_W    = 4,
   parameter int unsigned WORD_W   = 32
) (
   input logic                   clk,
   input logic                   reset,
   rc4_keystream_decrypt_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(KS_DEPTH);
   localparam int unsigned NIBS   = WORD_W / NIB_W;
   localparam int unsigned FCNT_W = $clog2(NIBS + 1);

   localparam logic [2:0] WAIT_KS = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] KEY_RDY = 3'd2;
   localparam logic [2:0] OUT     = 3'd3;
   localparam logic [2:0] REKEY   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [WORD_W-1:0] key_q, key_d;
   logic [WORD_W-1:0] pt_data_q, pt_data_d;
   logic              pt_valid_q, pt_valid_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic              first_q, first_d;
   logic              ks_prev_q;
   logic              fetch_rd;

   // FETCH spends NIBS cycles issuing reads plus one more to land the last nibble.
   assign fetch_rd = (state_q == FETCH) && (fcnt_q < FCNT_W'(NIBS));

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      fcnt_d     = fcnt_q;
      key_d      = key_q;
      pt_data_d  = pt_data_q;
      pt_valid_d = pt_valid_q;
      word_cnt_d = word_cnt_q;
      first_d    = first_q;
      case (state_q)
         WAIT_KS: begin
            if (bus.ks_ready && (!ks_prev_q || first_q)) begin
               state_d = FETCH;
               fcnt_d  = '0;
               first_d = 1'b0;
            end
         end
         FETCH: begin
            // Read k returns one cycle later, when fcnt_q has advanced to k+1.
            for (int unsigned k = 0; k < NIBS; k++) begin
               if (fcnt_q == FCNT_W'(k + 1)) key_d[k*NIB_W +: NIB_W] = bus.ks_data;
            end
            if (fetch_rd) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               fcnt_d   = fcnt_q + 1'b1;
            end else begin
               state_d = KEY_RDY;
            end
         end
         KEY_RDY: begin
            if (bus.ct_valid) begin
               pt_data_d  = bus.ct_data ^ key_q;
               pt_valid_d = 1'b1;
               state_d    = OUT;
            end
         end
         OUT: begin
            if (bus.pt_ready) begin
               word_cnt_d = word_cnt_q + 1'b1;
               pt_valid_d = 1'b0;
               fcnt_d     = '0;
               state_d    = (rd_ptr_q == '0) ? REKEY : FETCH;
            end
         end
         REKEY:   state_d = WAIT_KS;
         default: state_d = WAIT_KS;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= WAIT_KS;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
         key_q      <= '0;
         pt_data_q  <= '0;
         pt_valid_q <= 1'b0;
         word_cnt_q <= '0;
         first_q    <= 1'b1;
         ks_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
         key_q      <= key_d;
         pt_data_q  <= pt_data_d;
         pt_valid_q <= pt_valid_d;
         word_cnt_q <= word_cnt_d;
         first_q    <= first_d;
         ks_prev_q  <= bus.ks_ready;
      end
   end

   assign bus.ks_rd_en = fetch_rd;
   assign bus.ks_addr  = fetch_rd ? rd_ptr_q : '0;
   assign bus.ks_rekey = (state_q == REKEY);
   assign bus.ct_ready = (state_q == KEY_RDY);
   assign bus.pt_valid = pt_valid_q;
   assign bus.pt_data  = pt_data_q;
   assign bus.word_cnt = word_cnt_q;
endmodule

// File: tb/tb_rc4_keystream_decrypt.sv
// Directed and randomised bench for rc4_keystream_decrypt with a word-level
// keystream/XOR reference model checked on every cycle.
module tb_rc4_keystream_decrypt;
   localparam int unsigned TO = 300;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rc4_keystream_decrypt_if #(.KS_DEPTH(16), .NIB_W(4), .WORD_W(32)) bus ();
   rc4_keystream_decrypt #(.KS_DEPTH(16), .NIB_W(4), .WORD_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [3:0]  ks_mem [16];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   bit          stall_mode = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   // Keystream buffer: data appears the cycle after the read request.
   initial begin : ks_port
      logic       en;
      logic [3:0] a;
      bus.ks_data = '0;
      forever begin
         @(negedge clk);
         en = bus.ks_rd_en;
         a  = bus.ks_addr;
         @(posedge clk);
         #1;
         if (en) bus.ks_data = ks_mem[a];
      end
   end

   initial begin : stall_gen
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) bus.pt_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Reference model: each key word is 8 consecutive buffer nibbles, two words per load.
   logic [31:0] exp_q [$];
   logic [3:0]  exp_rd    = '0;
   int unsigned reads     = 0;
   int unsigned base      = 0;
   bit          cap_pend  = 1'b0;
   bit          key_ld    = 1'b0;
   bit          rekey_due = 1'b0;
   logic [7:0]  exp_cnt   = '0;

   initial begin : monitor
      logic [31:0] key;
      bit          ct_exp;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("reset_ctl", 32'({bus.ks_rd_en, bus.ks_addr, bus.ks_rekey, bus.ct_ready,
                                    bus.pt_valid, bus.word_cnt}), 32'd0);
            check("reset_pt", bus.pt_data, 32'd0);
            exp_q.delete();
            exp_rd = '0; reads = 0; base = 0; cap_pend = 1'b0; key_ld = 1'b0;
            rekey_due = 1'b0; exp_cnt = '0;
         end else begin
            check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
            check("pt_valid", 32'(bus.pt_valid), 32'(exp_q.size() != 0));
            if (bus.pt_valid && exp_q.size() != 0) check("pt_data", bus.pt_data, exp_q[0]);
            check("ks_rekey", 32'(bus.ks_rekey), 32'(rekey_due));
            rekey_due = 1'b0;
            ct_exp = key_ld && (exp_q.size() == 0);
            check("ct_ready", 32'(bus.ct_ready), 32'(ct_exp));
            if (cap_pend) begin
               cap_pend = 1'b0;
               key_ld   = 1'b1;
            end
            if (bus.ks_rd_en) begin
               check("rd_extra", 32'(reads < 8), 32'd1);
               check("ks_addr", 32'(bus.ks_addr), 32'(exp_rd));
               exp_rd = exp_rd + 4'd1;
               reads++;
               if (reads == 8) cap_pend = 1'b1;
            end
            if (bus.ct_valid && bus.ct_ready) begin
               key = '0;
               for (int unsigned k = 0; k < 8; k++)
                  key = key | (32'(ks_mem[(base + k) % 16]) << (4 * k));
               exp_q.push_back(bus.ct_data ^ key);
               base   = (base + 8) % 16;
               key_ld = 1'b0;
               reads  = 0;
            end
            if (bus.pt_valid && bus.pt_ready && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               exp_cnt = exp_cnt + 8'd1;
               if (base == 0) rekey_due = 1'b1;
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] ct, output logic [31:0] pt, output int unsigned lat);
      int unsigned n = 0;
      pt  = '0;
      lat = 0;
      bus.ct_data  = ct;
      bus.ct_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.ct_ready && n < TO);
      if (!bus.ct_ready) begin
         check("ct_timeout", 32'(bus.ct_ready), 32'd1);
         bus.ct_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.ct_valid = 1'b0;
      bus.ct_data  = $urandom();
      do begin
         @(negedge clk);
         n++;
         if (bus.pt_valid && lat == 0) lat = n;
      end while (!(bus.pt_valid && bus.pt_ready) && n < 2 * TO);
      if (!(bus.pt_valid && bus.pt_ready)) begin
         check("pt_timeout", 32'(bus.pt_valid && bus.pt_ready), 32'd1);
         return;
      end
      pt = bus.pt_data;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rekey();
      int unsigned n = 0;
      do begin @(negedge clk); n++; end while (!bus.ks_rekey && n < 50);
      if (!bus.ks_rekey) check("rekey_timeout", 32'(bus.ks_rekey), 32'd1);
   endtask

   task automatic reload_ks(input bit rnd);
      @(posedge clk);
      #1;
      bus.ks_ready = 1'b0;
      if (rnd) for (int i = 0; i < 16; i++) ks_mem[i] = 4'($urandom());
      repeat (2) @(posedge clk);
      #1;
      bus.ks_ready = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] pt, hold;
      int unsigned lat, n, bad;
      bit          found;
      reset        = 1'b0;
      bus.ks_ready = 1'b1;
      bus.ct_valid = 1'b0;
      bus.ct_data  = '0;
      bus.pt_ready = 1'b1;
      for (int i = 0; i < 16; i++) ks_mem[i] = 4'(i);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Identity keystream: word0 key 0x76543210, word1 key 0xFEDCBA98.
      send_word(32'hDEADBEEF, pt, lat);
      check("t1_pt", pt, 32'hA8F98CFF);
      check("t1_cnt", 32'(bus.word_cnt), 32'd1);

      send_word(32'h12345678, pt, lat);
      check("t4_latency", lat, 32'd11);
      check("t2_pt", pt, 32'hECE8ECE0);
      check("t2_cnt", 32'(bus.word_cnt), 32'd2);
      n = 0; bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ks_rekey) n++;
         if (bus.ct_ready || bus.ks_rd_en) bad++;
      end
      check("t2_rekey_pulses", n, 32'd1);
      check("t2_idle_no_edge", bad, 32'd0);
      reload_ks(1'b0);

      bus.pt_ready = 1'b0;
      bus.ct_data  = 32'h0F0F0F0F;
      bus.ct_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ct_ready && n < TO);
      @(posedge clk);
      #1;
      bus.ct_valid = 1'b0;
      @(negedge clk);
      hold = bus.pt_data;
      check("t3_valid", 32'(bus.pt_valid), 32'd1);
      check("t3_pt", hold, 32'h795B3D1F);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus.pt_valid || bus.pt_data !== hold || bus.ct_ready || bus.ks_rd_en) bad++;
      end
      check("t3_stall_stable", bad, 32'd0);
      @(posedge clk);
      #1;
      bus.pt_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t3_cnt", 32'(bus.word_cnt), 32'd3);

      send_word(32'hFFFFFFFF, pt, lat);
      check("t3b_pt", pt, 32'h01234567);
      wait_rekey();
      reload_ks(1'b0);

      found = 1'b0; n = 0;
      while (!found && n < TO) begin
         @(negedge clk);
         n++;
         if (bus.ks_rd_en && bus.ks_addr == 4'd5) found = 1'b1;
      end
      check("t5_addr5_seen", 32'(found), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("t5_async_ctl", 32'({bus.ks_rd_en, bus.ks_addr, bus.ks_rekey, bus.ct_ready,
                                 bus.pt_valid, bus.word_cnt}), 32'd0);
      check("t5_async_pt", bus.pt_data, 32'd0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ks_rd_en && n < TO);
      check("t5_restart_rd", 32'(bus.ks_rd_en), 32'd1);
      check("t5_restart_addr", 32'(bus.ks_addr), 32'd0);

      stall_mode = 1'b1;
      for (int unsigned p = 0; p < 128; p++) begin
         if (p != 0) begin
            wait_rekey();
            reload_ks(1'b1);
         end
         for (int unsigned w = 0; w < 2; w++) begin
            send_word($urandom(), pt, lat);
            if (p == 127 && w == 0) check("t6_cnt255", 32'(bus.word_cnt), 32'd255);
         end
      end
      stall_mode = 1'b0;
      #2;
      bus.pt_ready = 1'b1;
      check("t6_cnt_wrap", 32'(bus.word_cnt), 32'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
